// File: rtl/rom_access_pkg.sv
// Shared types and limits for the cartridge SRAM access controller.
package rom_access_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SNES_ACC = 2'd1,
    MCU_ACC  = 2'd2,
    RECOVER  = 2'd3
  } state_t;

  localparam int ACCESS_CYCLES_MIN = 3;
  localparam int ACCESS_CYCLES_MAX = 15;

  typedef struct packed {
    logic [23:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } req_t;

endpackage

// File: rtl/rom_req_latch.sv
// One-deep request holding register. A set while already full (and not being
// drained in the same cycle) drops the new request and flags an overrun.
module rom_req_latch
  import rom_access_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic set,
  input  logic clr,
  input  req_t req_in,
  output req_t req_out,
  output logic valid,
  output logic overrun
);

  logic valid_reg;
  req_t req_reg;
  logic set_eff;

  // A new request is stored only if the slot is free or being emptied now.
  assign set_eff = set && (!valid_reg || clr);

  // Holding register and valid flag; a simultaneous set/clear keeps the new request.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_reg <= 1'b0;
      req_reg   <= '0;
    end else if (set_eff) begin
      valid_reg <= 1'b1;
      req_reg   <= req_in;
    end else if (clr) begin
      valid_reg <= 1'b0;
    end
  end

  assign req_out = req_reg;
  assign valid   = valid_reg;
  assign overrun = set && valid_reg && !clr;

endmodule

// File: rtl/rom_access_ctrl.sv
// Arbitrates SNES and MCU requests onto the 16-bit cartridge SRAM, sequencing
// chip strobes, steering byte lanes and returning read data with an ack.
module rom_access_ctrl
  import rom_access_pkg::*;
#(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        snes_req,
  input  logic [23:0] snes_addr,
  input  logic        snes_we,
  input  logic [7:0]  snes_wdata,
  output logic [7:0]  snes_rdata,
  output logic        snes_ack,
  output logic        snes_overrun,
  input  logic        mcu_req,
  input  logic [23:0] mcu_addr,
  input  logic        mcu_we,
  input  logic [7:0]  mcu_wdata,
  output logic [7:0]  mcu_rdata,
  output logic        mcu_rdy,
  output logic [22:0] ROM_ADDR,
  output logic [15:0] ROM_DATA_OUT,
  output logic        ROM_DATA_OE,
  input  logic [15:0] ROM_DATA_IN,
  output logic        ROM_CE_N,
  output logic        ROM_OE_N,
  output logic        ROM_WE_N,
  output logic        ROM_BHE_N,
  output logic        ROM_BLE_N
);

  if (ACCESS_CYCLES < ACCESS_CYCLES_MIN || ACCESS_CYCLES > ACCESS_CYCLES_MAX) begin : g_bad_cycles
    $error("rom_access_ctrl: ACCESS_CYCLES out of range 3..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [22:0] addr_reg, addr_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic        lane_reg, lane_next;
  logic        doe_reg, doe_next;
  logic        ce_n_reg, ce_n_next;
  logic        oe_n_reg, oe_n_next;
  logic        we_n_reg, we_n_next;
  logic        bhe_n_reg, bhe_n_next;
  logic        ble_n_reg, ble_n_next;
  logic [7:0]  snes_rdata_reg, snes_rdata_next;
  logic [7:0]  mcu_rdata_reg, mcu_rdata_next;
  logic        snes_ack_reg, snes_ack_next;
  logic        mcu_rdy_reg, mcu_rdy_next;

  req_t snes_fresh, mcu_cur, latch_req, snes_sel, acc;
  logic latch_valid, latch_set, latch_clr;
  logic snes_pending, start_snes, start_mcu;
  logic [7:0] lane_byte;

  assign snes_fresh   = {snes_addr, snes_we, snes_wdata};
  assign mcu_cur      = {mcu_addr, mcu_we, mcu_wdata};
  assign snes_pending = snes_req || latch_valid;
  assign start_snes   = (state_reg == IDLE) && snes_pending;
  assign start_mcu    = (state_reg == IDLE) && !snes_pending && mcu_req;
  // The latched request is older, so it is served before a fresh pulse.
  assign snes_sel     = latch_valid ? latch_req : snes_fresh;
  assign acc          = start_snes ? snes_sel : mcu_cur;
  // A fresh pulse bypasses the latch only when it is accepted directly.
  assign latch_set    = snes_req && !((state_reg == IDLE) && !latch_valid);
  assign latch_clr    = start_snes && latch_valid;
  assign lane_byte    = lane_reg ? ROM_DATA_IN[15:8] : ROM_DATA_IN[7:0];

  rom_req_latch u_snes_latch (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .set     (latch_set),
    .clr     (latch_clr),
    .req_in  (snes_fresh),
    .req_out (latch_req),
    .valid   (latch_valid),
    .overrun (snes_overrun)
  );

  // State, counter and all registered pin/response values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      lane_reg       <= 1'b0;
      doe_reg        <= 1'b0;
      ce_n_reg       <= 1'b1;
      oe_n_reg       <= 1'b1;
      we_n_reg       <= 1'b1;
      bhe_n_reg      <= 1'b1;
      ble_n_reg      <= 1'b1;
      snes_rdata_reg <= '0;
      mcu_rdata_reg  <= '0;
      snes_ack_reg   <= 1'b0;
      mcu_rdy_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      lane_reg       <= lane_next;
      doe_reg        <= doe_next;
      ce_n_reg       <= ce_n_next;
      oe_n_reg       <= oe_n_next;
      we_n_reg       <= we_n_next;
      bhe_n_reg      <= bhe_n_next;
      ble_n_reg      <= ble_n_next;
      snes_rdata_reg <= snes_rdata_next;
      mcu_rdata_reg  <= mcu_rdata_next;
      snes_ack_reg   <= snes_ack_next;
      mcu_rdy_reg    <= mcu_rdy_next;
    end
  end

  // Next-state logic; pin values change on the edge that enters each state.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    lane_next       = lane_reg;
    doe_next        = doe_reg;
    ce_n_next       = ce_n_reg;
    oe_n_next       = oe_n_reg;
    we_n_next       = we_n_reg;
    bhe_n_next      = bhe_n_reg;
    ble_n_next      = ble_n_reg;
    snes_rdata_next = snes_rdata_reg;
    mcu_rdata_next  = mcu_rdata_reg;
    snes_ack_next   = 1'b0;
    mcu_rdy_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_snes || start_mcu) begin
          state_next = start_snes ? SNES_ACC : MCU_ACC;
          cnt_next   = CNT_LOAD;
          addr_next  = acc.addr[23:1];
          wdata_next = acc.wdata;
          lane_next  = acc.addr[0];
          doe_next   = acc.we;
          ce_n_next  = 1'b0;
          oe_n_next  = acc.we;
          we_n_next  = !acc.we;
          bhe_n_next = !acc.addr[0];
          ble_n_next = acc.addr[0];
        end
      end
      SNES_ACC, MCU_ACC: begin
        if (cnt_reg == 4'd0) begin
          // Last window cycle: sample read data and release the bus.
          state_next = RECOVER;
          ce_n_next  = 1'b1;
          oe_n_next  = 1'b1;
          we_n_next  = 1'b1;
          bhe_n_next = 1'b1;
          ble_n_next = 1'b1;
          doe_next   = 1'b0;
          if (state_reg == SNES_ACC) begin
            snes_ack_next = 1'b1;
            if (!doe_reg) snes_rdata_next = lane_byte;
          end else begin
            mcu_rdy_next = 1'b1;
            if (!doe_reg) mcu_rdata_next = lane_byte;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
          // WE_N rises one cycle early so address and data are held past it.
          if (cnt_reg == 4'd1) we_n_next = 1'b1;
        end
      end
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign ROM_DATA_OUT[gi*8 +: 8] = wdata_reg;
  end

  assign ROM_ADDR    = addr_reg;
  assign ROM_DATA_OE = doe_reg;
  assign ROM_CE_N    = ce_n_reg;
  assign ROM_OE_N    = oe_n_reg;
  assign ROM_WE_N    = we_n_reg;
  assign ROM_BHE_N   = bhe_n_reg;
  assign ROM_BLE_N   = ble_n_reg;
  assign snes_rdata  = snes_rdata_reg;
  assign mcu_rdata   = mcu_rdata_reg;
  assign snes_ack    = snes_ack_reg;
  assign mcu_rdy     = mcu_rdy_reg;

endmodule
